sprite_palette_lut: RTL and testbench

Parametrised, writable, pipelined palette lookup for character sprites. It maps a per-pixel colour index plus a palette select to 12-bit-class RGB, and flags the transparent index. It adds runtime palette rewrite (player-2 alternate colours), a frame-timed hit-flash effect, and brightness dimming. It sits between each sprite ROM reader and the layer compositor, and replaces fixed per-sprite palette ROMs.

---
 rtl/sprite_palette_lut.sv | 164 ++++++++++++++++
 tb/tb_sprite_palette_lut.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_lut.sv
// Writable, two-stage pipelined sprite palette lookup with hit-flash and dimming.
// Palette RAM is zeroed by an INIT walk after reset before lookups are accepted.
module sprite_palette_lut #(
    parameter  int IDX_W           = 4,
    parameter  int NUM_PAL         = 4,
    parameter  int COLOR_W         = 4,
    parameter  int TRANSPARENT_IDX = 15,
    parameter  int FLASH_FRAMES    = 8,
    localparam int PS_W            = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 pix_valid,
    input  logic [IDX_W-1:0]     pix_index,
    input  logic [PS_W-1:0]      pal_sel,
    input  logic [1:0]           dim,
    input  logic                 flash_trig,
    input  logic                 frame_tick,
    input  logic                 wr_en,
    input  logic [PS_W-1:0]      wr_pal,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0] wr_data,
    output logic                 ready,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent
);

    localparam int E     = 1 << IDX_W;
    localparam int DEPTH = NUM_PAL * E;
    localparam int AW    = PS_W + IDX_W;
    localparam int RGB_W = 3 * COLOR_W;
    localparam logic [PS_W:0] NUM_PAL_CMP = (PS_W + 1)'(NUM_PAL);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic [7:0]      flash_q;

    logic [RGB_W-1:0] mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [RGB_W-1:0] mem_wdata;
    logic [AW-1:0]    rd_addr;
    logic [PS_W-1:0]  rd_pal;
    logic [RGB_W-1:0] rd_q;

    logic             s1_valid;
    logic             s1_transp;
    logic             s1_flash;
    logic [1:0]       s1_dim;

    assign ready = (state_q == ST_RUN);

    // ---------------- Init / run control ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Writes to a palette number beyond NUM_PAL are dropped; reads fall back to palette 0.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt_q;
        mem_wdata = '0;
        if (Reset_n) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
            end else if (wr_en && ({1'b0, wr_pal} < NUM_PAL_CMP)) begin
                mem_we    = 1'b1;
                mem_waddr = {wr_pal, wr_addr};
                mem_wdata = wr_data;
            end
        end
    end

    assign rd_pal  = ({1'b0, pal_sel} < NUM_PAL_CMP) ? pal_sel : '0;
    assign rd_addr = {rd_pal, pix_index};

    // NOTE: the RAM has no reset (the INIT walk clears it); non-blocking read and write in one block
    // make a same-address read in the write cycle return the old word.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_q <= mem[rd_addr];
    end

    // ---------------- Flash burst counter ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flash_q <= '0;
        end else if (flash_trig) begin
            flash_q <= 8'(FLASH_FRAMES);
        end else if (frame_tick && (flash_q != '0)) begin
            flash_q <= flash_q - 1'b1;
        end
    end

    // ---------------- Stage 1: sideband alongside the RAM read ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_transp <= 1'b0;
            s1_flash  <= 1'b0;
            s1_dim    <= '0;
        end else begin
            s1_valid  <= pix_valid && ready;
            s1_transp <= (pix_index == IDX_W'(TRANSPARENT_IDX));
            s1_flash  <= flash_q[0];
            s1_dim    <= dim;
        end
    end

    // ---------------- Stage 2: flash/dim and output registers ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                transparent <= s1_transp;
                if (s1_flash && !s1_transp) begin
                    red   <= '1;
                    green <= '1;
                    blue  <= '1;
                end else begin
                    red   <= rd_q[RGB_W-1 -: COLOR_W] >> s1_dim;
                    green <= rd_q[2*COLOR_W-1 -: COLOR_W] >> s1_dim;
                    blue  <= rd_q[COLOR_W-1:0] >> s1_dim;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Self-checking bench for sprite_palette_lut: directed test-plan steps plus randomized
// traffic, all checked every cycle against a behavioural palette/flash model.
module tb_sprite_palette_lut;

    localparam int IDX_W        = 4;
    localparam int NUM_PAL      = 4;
    localparam int COLOR_W      = 4;
    localparam int PS_W         = 2;
    localparam int DEPTH        = 64;
    localparam int FLASH_FRAMES = 8;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 pix_valid = 1'b0;
    logic [IDX_W-1:0]     pix_index = '0;
    logic [PS_W-1:0]      pal_sel = '0;
    logic [1:0]           dim = '0;
    logic                 flash_trig = 1'b0;
    logic                 frame_tick = 1'b0;
    logic                 wr_en = 1'b0;
    logic [PS_W-1:0]      wr_pal = '0;
    logic [IDX_W-1:0]     wr_addr = '0;
    logic [3*COLOR_W-1:0] wr_data = '0;
    logic                 ready;
    logic                 out_valid;
    logic [COLOR_W-1:0]   red, green, blue;
    logic                 transparent;

    sprite_palette_lut dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_valid   (pix_valid),
        .pix_index   (pix_index),
        .pal_sel     (pal_sel),
        .dim         (dim),
        .flash_trig  (flash_trig),
        .frame_tick  (frame_tick),
        .wr_en       (wr_en),
        .wr_pal      (wr_pal),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ready       (ready),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [3*COLOR_W-1:0] m_mem [NUM_PAL][1 << IDX_W];
    bit m_ready;
    int m_init_left;
    int m_flash;
    bit m_pend_valid, m_pend_t;
    int m_pend_r, m_pend_g, m_pend_b;
    bit e_valid, e_t;
    int e_r, e_g, e_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, applied to the inputs present at that edge.
    task automatic model_edge();
        int w, div;
        if (!Reset_n) begin
            m_ready = 0;
            m_init_left = DEPTH;
            m_flash = 0;
            m_pend_valid = 0;
            e_valid = 0; e_t = 0; e_r = 0; e_g = 0; e_b = 0;
            for (int p = 0; p < NUM_PAL; p++)
                for (int a = 0; a < (1 << IDX_W); a++)
                    m_mem[p][a] = '0;
        end else begin
            e_valid = m_pend_valid;
            if (m_pend_valid) begin
                e_r = m_pend_r; e_g = m_pend_g; e_b = m_pend_b; e_t = m_pend_t;
            end
            m_pend_valid = m_ready && pix_valid;
            if (m_pend_valid) begin
                w   = int'(m_mem[pal_sel][pix_index]);
                div = 1 << int'(dim);
                m_pend_t = (int'(pix_index) == 15);
                if ((m_flash % 2 == 1) && !m_pend_t) begin
                    m_pend_r = 15; m_pend_g = 15; m_pend_b = 15;
                end else begin
                    m_pend_r = ((w / 256) % 16) / div;
                    m_pend_g = ((w / 16) % 16) / div;
                    m_pend_b = (w % 16) / div;
                end
            end
            if (m_ready && wr_en) m_mem[wr_pal][wr_addr] = wr_data;
            if (flash_trig) m_flash = FLASH_FRAMES;
            else if (frame_tick && m_flash > 0) m_flash = m_flash - 1;
            if (!m_ready) begin
                m_init_left = m_init_left - 1;
                if (m_init_left == 0) m_ready = 1;
            end
        end
    endtask

    task automatic compare();
        check("ready",       32'(ready),       32'(m_ready));
        check("out_valid",   32'(out_valid),   32'(e_valid));
        check("red",         32'(red),         32'(e_r));
        check("green",       32'(green),       32'(e_g));
        check("blue",        32'(blue),        32'(e_b));
        check("transparent", 32'(transparent), 32'(e_t));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        compare();
        pix_valid  = 1'b0;
        wr_en      = 1'b0;
        flash_trig = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic req(input int pal, input int idx, input int d);
        pix_valid = 1'b1;
        pal_sel   = PS_W'(pal);
        pix_index = IDX_W'(idx);
        dim       = 2'(d);
    endtask

    task automatic wr(input int pal, input int addr, input int data);
        wr_en   = 1'b1;
        wr_pal  = PS_W'(pal);
        wr_addr = IDX_W'(addr);
        wr_data = 12'(data);
    endtask

    task automatic check_rgb(input string tag, input int rgb);
        check({tag, "_r"}, 32'(red),   32'((rgb / 256) % 16));
        check({tag, "_g"}, 32'(green), 32'((rgb / 16) % 16));
        check({tag, "_b"}, 32'(blue),  32'(rgb % 16));
    endtask

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pix_valid  = ($urandom_range(3) != 0);
            pix_index  = IDX_W'($urandom);
            pal_sel    = PS_W'($urandom);
            dim        = 2'($urandom);
            wr_en      = ($urandom_range(3) == 0);
            wr_pal     = PS_W'($urandom);
            wr_addr    = IDX_W'($urandom);
            wr_data    = 12'($urandom);
            flash_trig = ($urandom_range(39) == 0);
            frame_tick = ($urandom_range(7) == 0);
            tick();
        end
    endtask

    initial begin
        int n;

        // Reset and INIT length
        Reset_n = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check_rgb("rst_rgb", 0);
        Reset_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("init_len", 32'(n), 32'd64);

        // Lookup at the first ready cycle reads zeroed RAM
        req(2, 5, 0);
        tick();
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check_rgb("first_rgb", 0);

        // Write then lookup, plain and dimmed
        wr(2, 5, 'hF84);
        tick();
        req(2, 5, 0);
        tick();
        tick();
        check_rgb("wl", 'hF84);
        check("wl_transp", 32'(transparent), 32'd0);
        req(2, 5, 2);
        tick();
        tick();
        check_rgb("dim2", 'h321);

        // Same-cycle read/write returns old data, next cycle sees new
        wr(1, 3, 'hABC);
        req(1, 3, 0);
        tick();
        req(1, 3, 0);
        tick();
        check_rgb("coll_old", 'h000);
        tick();
        check_rgb("coll_new", 'hABC);

        // Transparent index
        wr(0, 15, 'hF0F);
        tick();
        req(0, 15, 0);
        tick();
        tick();
        check("transp", 32'(transparent), 32'd1);
        check_rgb("transp_rgb", 'hF0F);

        // Flash burst: counter 8 down to 0, odd values flash opaque pixels
        wr(3, 1, 'h123);
        tick();
        flash_trig = 1'b1;
        tick();
        for (int k = 0; k <= FLASH_FRAMES; k++) begin
            req(3, 1, 1);
            tick();
            req(0, 15, 0);
            tick();
            check_rgb("flash_px", ((FLASH_FRAMES - k) % 2 == 1) ? 'hFFF : 'h011);
            tick();
            check_rgb("flash_tp", 'hF0F);
            frame_tick = 1'b1;
            tick();
        end

        // Trigger coinciding with a frame tick reloads; next tick gives odd count
        flash_trig = 1'b1;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b1;
        tick();
        req(3, 1, 0);
        tick();
        tick();
        check_rgb("trig_tick", 'hFFF);
        repeat (FLASH_FRAMES) begin
            frame_tick = 1'b1;
            tick();
        end

        // Randomized traffic against the model
        random_traffic(400);

        // Mid-stream reset with continuous lookups
        wr(2, 5, 'hF84);
        tick();
        repeat (5) begin
            req(int'($urandom_range(3)), int'($urandom_range(15)), 0);
            tick();
        end
        req(2, 5, 0);
        Reset_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        Reset_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            req(2, 5, 0);
            tick();
            n++;
        end
        check("reinit_len", 32'(n), 32'd64);
        req(2, 5, 0);
        tick();
        tick();
        check("reinit_valid", 32'(out_valid), 32'd1);
        check_rgb("reinit_rgb", 'h000);

        random_traffic(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
